// File: rtl/mib_pkg.sv
// mib_pkg: MIB framing constants and slave FSM state type shared by mib_master and mib_cmd_slave
package mib_pkg;
    localparam int MIB_AD_BITS = 16;
    localparam int MIB_MSN_LSB = 20;
    localparam int MIB_PH_A1   = 0;
    localparam int MIB_PH_A2   = 1;
    localparam int MIB_PH_D_HI = 2;
    localparam int MIB_PH_D_LO = 3;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_WDATA_HI,
        ST_WDATA_LO,
        ST_CMD_WAIT,
        ST_RD_HI,
        ST_RD_LO
    } mib_slv_state_t;
endpackage

// File: rtl/mib_cmd_slave.sv
// mib_cmd_slave: MIB bus responder replaying each MIB access as one local cmd transaction
// Ports: i_sysclk/i_srst clock and sync reset; i_mib_* / o_mib_* MIB side (start, dir, AD in/out,
// AD output enable, slave ack); o_cmd_* / i_cmd_* local cmd master (sel strobe, dir, byte address,
// write data, read data, ack); o_cmd_timeout pulses when the local ack never arrives.
module mib_cmd_slave
    import mib_pkg::*;
#(
    parameter logic [3:0] P_MIB_MSN              = 4'h0,
    parameter int         ADDR_BITS              = 24,
    parameter int         DATA_BITS              = 32,
    parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
    input  logic                   i_sysclk,
    input  logic                   i_srst,
    input  logic                   i_mib_start,
    input  logic                   i_mib_rd_wr_n,
    input  logic [MIB_AD_BITS-1:0] i_mib_ad,
    output logic [MIB_AD_BITS-1:0] o_mib_ad,
    output logic                   o_mib_ad_oe,
    output logic                   o_mib_slave_ack,
    output logic                   o_cmd_sel,
    output logic                   o_cmd_rd_wr_n,
    output logic [ADDR_BITS-1:0]   o_cmd_byte_addr,
    output logic [DATA_BITS-1:0]   o_cmd_wdata,
    input  logic [DATA_BITS-1:0]   i_cmd_rdata,
    input  logic                   i_cmd_ack,
    output logic                   o_cmd_timeout
);
    localparam int CW = $clog2(P_CMD_ACK_TIMEOUT_CLKS);

    mib_slv_state_t       state;
    logic [CW-1:0]        cnt;
    logic                 wr_ack;
    logic [DATA_BITS-1:0] rdata;

    // Read data goes out straight from the state so a reset during RD_HI/RD_LO drops oe next clock.
    assign o_mib_ad_oe     = (state == ST_RD_HI) || (state == ST_RD_LO);
    assign o_mib_slave_ack = o_mib_ad_oe || wr_ack;
    assign o_mib_ad        = (state == ST_RD_HI) ? rdata[DATA_BITS-1 -: MIB_AD_BITS] :
                             (state == ST_RD_LO) ? rdata[MIB_AD_BITS-1:0] : '0;

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            wr_ack          <= 1'b0;
            rdata           <= '0;
            o_cmd_sel       <= 1'b0;
            o_cmd_rd_wr_n   <= 1'b0;
            o_cmd_byte_addr <= '0;
            o_cmd_wdata     <= '0;
            o_cmd_timeout   <= 1'b0;
        end else begin
            o_cmd_sel     <= 1'b0;
            wr_ack        <= 1'b0;
            o_cmd_timeout <= 1'b0;
            case (state)
                ST_IDLE: if (i_mib_start) begin
                    o_cmd_byte_addr[ADDR_BITS-1 -: 8] <= i_mib_ad[7:0];
                    o_cmd_rd_wr_n                     <= i_mib_rd_wr_n;
                    state                             <= ST_ADDR2;
                end
                ST_ADDR2: begin
                    o_cmd_byte_addr[15:0] <= i_mib_ad;
                    // Upper byte was captured in A1, so the nibble decode can happen now.
                    if (o_cmd_byte_addr[MIB_MSN_LSB +: 4] != P_MIB_MSN) begin
                        state <= ST_IDLE;
                    end else if (o_cmd_rd_wr_n) begin
                        o_cmd_sel <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_CMD_WAIT;
                    end else begin
                        state <= ST_WDATA_HI;
                    end
                end
                ST_WDATA_HI: begin
                    o_cmd_wdata[DATA_BITS-1 -: MIB_AD_BITS] <= i_mib_ad;
                    state                                   <= ST_WDATA_LO;
                end
                ST_WDATA_LO: begin
                    o_cmd_wdata[MIB_AD_BITS-1:0] <= i_mib_ad;
                    o_cmd_sel                    <= 1'b1;
                    cnt                          <= '0;
                    state                        <= ST_CMD_WAIT;
                end
                ST_CMD_WAIT: begin
                    // cnt is 0 in the sel cycle; an ack on the last count beats the timeout.
                    if (i_cmd_ack) begin
                        rdata  <= o_cmd_rd_wr_n ? i_cmd_rdata : rdata;
                        wr_ack <= !o_cmd_rd_wr_n;
                        state  <= o_cmd_rd_wr_n ? ST_RD_HI : ST_IDLE;
                    end else if (cnt == CW'(P_CMD_ACK_TIMEOUT_CLKS - 1)) begin
                        o_cmd_timeout <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RD_HI: state <= ST_RD_LO;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mib_cmd_slave.sv
// tb_mib_cmd_slave: directed self-checking bench for mib_cmd_slave
module tb_mib_cmd_slave;
    logic        clk;
    logic        srst;
    logic        mib_start;
    logic        mib_rd_wr_n;
    logic [15:0] mib_ad_in;
    logic [15:0] mib_ad_out;
    logic        mib_ad_oe;
    logic        mib_slave_ack;
    logic        cmd_sel;
    logic        cmd_rd_wr_n;
    logic [23:0] cmd_byte_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_rdata;
    logic        cmd_ack;
    logic        cmd_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int sel_cnt     = 0;
    int sack_cnt    = 0;
    int oe_cnt      = 0;
    int to_cnt      = 0;
    int s_sel, s_sack, s_oe;
    logic [31:0] mem [logic [23:0]];

    mib_cmd_slave dut (
        .i_sysclk        (clk),
        .i_srst          (srst),
        .i_mib_start     (mib_start),
        .i_mib_rd_wr_n   (mib_rd_wr_n),
        .i_mib_ad        (mib_ad_in),
        .o_mib_ad        (mib_ad_out),
        .o_mib_ad_oe     (mib_ad_oe),
        .o_mib_slave_ack (mib_slave_ack),
        .o_cmd_sel       (cmd_sel),
        .o_cmd_rd_wr_n   (cmd_rd_wr_n),
        .o_cmd_byte_addr (cmd_byte_addr),
        .o_cmd_wdata     (cmd_wdata),
        .i_cmd_rdata     (cmd_rdata),
        .i_cmd_ack       (cmd_ack),
        .o_cmd_timeout   (cmd_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        sel_cnt  <= sel_cnt + int'(cmd_sel);
        sack_cnt <= sack_cnt + int'(mib_slave_ack);
        oe_cnt   <= oe_cnt + int'(mib_ad_oe);
        to_cnt   <= to_cnt + int'(cmd_timeout);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start and end positioned at a negedge, ready to drive.
    task automatic start_access(input logic rd, input logic [23:0] a);
        mib_start   = 1'b1;
        mib_rd_wr_n = rd;
        mib_ad_in   = {8'hA5, a[23:16]};
        @(negedge clk);
        mib_start   = 1'b0;
        mib_rd_wr_n = 1'b0;
        mib_ad_in   = a[15:0];
        @(negedge clk);
    endtask

    task automatic write_txn(input string tag, input logic [23:0] a, input logic [31:0] d, input int dly);
        start_access(1'b0, a);
        chk({tag, "_nosel_c2"}, 32'(cmd_sel), 32'd0);
        mib_ad_in = d[31:16];
        @(negedge clk);
        mib_ad_in = d[15:0];
        @(negedge clk);
        mib_ad_in = '0;
        chk({tag, "_sel"}, 32'(cmd_sel), 32'd1);
        chk({tag, "_addr"}, 32'(cmd_byte_addr), 32'(a));
        chk({tag, "_wdata"}, cmd_wdata, d);
        chk({tag, "_dir"}, 32'(cmd_rd_wr_n), 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, "_wait_noack"}, 32'(mib_slave_ack), 32'd0);
        end
        cmd_ack = 1'b1;
        mem[a]  = d;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk({tag, "_ack"}, 32'(mib_slave_ack), 32'd1);
        chk({tag, "_ack_oe"}, 32'(mib_ad_oe), 32'd0);
    endtask

    task automatic read_txn(input string tag, input logic [23:0] a, input logic [31:0] exp, input int dly);
        start_access(1'b1, a);
        chk({tag, "_sel"}, 32'(cmd_sel), 32'd1);
        chk({tag, "_addr"}, 32'(cmd_byte_addr), 32'(a));
        chk({tag, "_dir"}, 32'(cmd_rd_wr_n), 32'd1);
        chk({tag, "_oe_sel"}, 32'(mib_ad_oe), 32'd0);
        for (int i = 0; i < dly; i++) @(negedge clk);
        cmd_ack   = 1'b1;
        cmd_rdata = mem.exists(a) ? mem[a] : 32'h0;
        @(negedge clk);
        cmd_ack   = 1'b0;
        cmd_rdata = 32'hFFFF_FFFF;
        chk({tag, "_hi"}, {mib_ad_oe, mib_slave_ack, cmd_timeout, 13'd0, mib_ad_out},
            {3'b110, 13'd0, exp[31:16]});
        @(negedge clk);
        chk({tag, "_lo"}, {mib_ad_oe, mib_slave_ack, cmd_timeout, 13'd0, mib_ad_out},
            {3'b110, 13'd0, exp[15:0]});
        @(negedge clk);
        chk({tag, "_end"}, {mib_ad_oe, mib_slave_ack, 14'd0, mib_ad_out}, 32'd0);
    endtask

    initial begin
        srst        = 1'b1;
        mib_start   = 1'b0;
        mib_rd_wr_n = 1'b0;
        mib_ad_in   = '0;
        cmd_rdata   = '0;
        cmd_ack     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mib", {mib_ad_oe, mib_slave_ack, 14'd0, mib_ad_out}, 32'd0);
        chk("reset_cmd", {cmd_sel, cmd_rd_wr_n, cmd_timeout, 5'd0, cmd_byte_addr}, 32'd0);
        chk("reset_wdata", cmd_wdata, 32'd0);
        srst = 1'b0;
        @(negedge clk);

        // 1: write with local ack two clocks after sel
        s_sel = sel_cnt;
        write_txn("t1_wr", 24'h000004, 32'h0101_0202, 2);
        @(negedge clk);
        chk("t1_ack_pulse", 32'(mib_slave_ack), 32'd0);
        chk("t1_one_sel", 32'(sel_cnt - s_sel), 32'd1);

        // 2: read back
        read_txn("t2_rd", 24'h000004, 32'h0101_0202, 2);

        // 3: foreign address nibble is ignored entirely
        s_sel = sel_cnt; s_sack = sack_cnt; s_oe = oe_cnt;
        start_access(1'b0, 24'h100000);
        mib_ad_in = 16'h1111;
        @(negedge clk);
        mib_ad_in = 16'h2222;
        repeat (6) @(negedge clk);
        start_access(1'b1, 24'h100000);
        repeat (6) @(negedge clk);
        chk("t3_no_sel", 32'(sel_cnt - s_sel), 32'd0);
        chk("t3_no_ack", 32'(sack_cnt - s_sack), 32'd0);
        chk("t3_no_oe", 32'(oe_cnt - s_oe), 32'd0);

        // 4: withheld local ack times out 16 clocks after sel
        s_sack = sack_cnt;
        start_access(1'b1, 24'h000008);
        chk("t4_sel", 32'(cmd_sel), 32'd1);
        for (int i = 1; i < 16; i++) @(negedge clk);
        chk("t4_no_to_yet", 32'(cmd_timeout), 32'd0);
        @(negedge clk);
        chk("t4_timeout", 32'(cmd_timeout), 32'd1);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("t4_to_pulse", 32'(cmd_timeout), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_mib_ack", 32'(sack_cnt - s_sack), 32'd0);
        mem[24'h000000] = 32'hDEAD_BEEF;
        read_txn("t4_rd0", 24'h000000, 32'hDEAD_BEEF, 0);
        mem[24'h000010] = 32'h5A5A_A5A5;
        read_txn("t4_last", 24'h000010, 32'h5A5A_A5A5, 15);
        chk("t4_one_timeout", 32'(to_cnt), 32'd1);

        // 5: reset during RD_HI aborts the read
        start_access(1'b1, 24'h000004);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'h0101_0202;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("t5_rd_hi", {mib_ad_oe, mib_slave_ack, 14'd0, mib_ad_out}, {2'b11, 14'd0, 16'h0101});
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("t5_abort", {mib_ad_oe, mib_slave_ack, 14'd0, mib_ad_out}, 32'd0);
        write_txn("t5_wr", 24'h00000C, 32'h1234_5678, 1);
        @(negedge clk);

        // 6: write then read starting on the first IDLE clock
        write_txn("t6_wr", 24'h000020, 32'hCAFE_F00D, 0);
        read_txn("t6_rd", 24'h000020, 32'hCAFE_F00D, 1);
        read_txn("t6_rd_b2b", 24'h00000C, 32'h1234_5678, 3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
